// File: rtl/sockit_spi_xip.sv
// sockit_spi_xip
//
// Execute-in-place read sequencer for the SPI serializer. A 24-bit flash read
// request is turned into a run of serializer command-queue words (command,
// address, optional dummy, data, chip-select hold); the input-queue words that
// come back are gathered into one 32-bit response.
//
// Ports
//   spi_sclk          clock, all state on the rising edge
//   rst               asynchronous active-high reset
//   cfg_mod           read mode: 0 read 0x03, 1 fast read 0x0B,
//                     2 quad-output read 0x6B, 3 behaves as 0
//   cfg_hld           chip-select-high cycles after a transaction, minus 1
//   req_vld/adr/rdy   read request handshake, 24-bit byte address
//   rsp_vld/dat/rdy   read response handshake, first received byte in [7:0]
//   quo_vld/ctl/dat   serializer command queue
//                     ctl = {cnt[SDL-1:0], lst, iom[1:0], die, doe, ss, ce}
//   quo_rdy           serializer command queue ready
//   qui_vld/ctl/dat   serializer input queue, ctl = {new, lst, iom[1:0]}
//   qui_rdy           input queue ready
//   bsy               sequencer active or response collection pending
module sockit_spi_xip #(
  parameter int unsigned SDW = 8,
  parameter int unsigned SDL = 3,
  parameter int unsigned QCO = SDL + 7,
  parameter int unsigned QCI = 4,
  parameter int unsigned QDW = 4 * SDW
) (
  input  logic           spi_sclk,
  input  logic           rst,
  input  logic [1:0]     cfg_mod,
  input  logic [SDL-1:0] cfg_hld,
  input  logic           req_vld,
  input  logic [23:0]    req_adr,
  output logic           req_rdy,
  output logic           rsp_vld,
  output logic [31:0]    rsp_dat,
  input  logic           rsp_rdy,
  output logic           quo_vld,
  output logic [QCO-1:0] quo_ctl,
  output logic [QDW-1:0] quo_dat,
  input  logic           quo_rdy,
  input  logic           qui_vld,
  input  logic [QCI-1:0] qui_ctl,
  input  logic [QDW-1:0] qui_dat,
  output logic           qui_rdy,
  output logic           bsy
);

  typedef enum logic [2:0] {
    IDLE, CMD, AD2, AD1, AD0, DUM, DAT, HLD
  } state_t;

  // Command-queue control words (cnt = 7, i.e. 8 clocks per word).
  localparam logic [QCO-1:0] CTL_OUT  = 10'h397;  // single lane drive
  localparam logic [QCO-1:0] CTL_DUM  = 10'h393;  // clocks only
  localparam logic [QCO-1:0] CTL_RD   = 10'h39B;  // single lane capture
  localparam logic [QCO-1:0] CTL_RDL  = 10'h3DB;  // single capture, last
  localparam logic [QCO-1:0] CTL_QRDL = 10'h3FB;  // quad capture, last

  localparam logic [1:0] MOD_READ = 2'd0;
  localparam logic [1:0] MOD_FAST = 2'd1;
  localparam logic [1:0] MOD_QUAD = 2'd2;

  localparam logic [1:0] IOM_SINGLE = 2'b01;
  localparam logic [1:0] IOM_QUAD   = 2'b11;

  state_t      state;
  logic [1:0]  mod;      // mode frozen at request acceptance
  logic [23:0] adr;
  logic [1:0]  dat_cnt;  // single-mode data word index

  logic        col_act;
  logic [1:0]  col_cnt;
  logic [31:0] col_dat;
  logic [31:0] col_nxt;
  logic [31:0] quad_word;

  logic        req_fire;
  logic        quo_fire;
  logic        qui_fire;
  logic        qui_lst;
  logic [1:0]  qui_iom;
  logic        unused;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign req_rdy  = (state == IDLE) & ~rsp_vld & ~col_act;
  assign quo_vld  = (state != IDLE);
  assign qui_rdy  = ~rsp_vld;
  assign bsy      = (state != IDLE) | col_act;

  assign req_fire = req_vld & req_rdy;
  assign quo_fire = quo_vld & quo_rdy;
  assign qui_fire = qui_vld & qui_rdy;

  assign qui_lst  = qui_ctl[2];
  assign qui_iom  = qui_ctl[1:0];
  assign unused   = qui_ctl[3];

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge spi_sclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mod     <= MOD_READ;
      adr     <= '0;
      dat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            adr     <= req_adr;
            mod     <= (cfg_mod == 2'd3) ? MOD_READ : cfg_mod;
            dat_cnt <= '0;
            state   <= CMD;
          end
        end
        CMD: if (quo_fire) state <= AD2;
        AD2: if (quo_fire) state <= AD1;
        AD1: if (quo_fire) state <= AD0;
        AD0: if (quo_fire) state <= (mod == MOD_READ) ? DAT : DUM;
        DUM: if (quo_fire) state <= DAT;
        DAT: begin
          if (quo_fire) begin
            if (mod == MOD_QUAD || dat_cnt == 2'd3) begin
              dat_cnt <= '0;
              state   <= HLD;
            end else begin
              dat_cnt <= dat_cnt + 2'd1;
            end
          end
        end
        HLD: if (quo_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Queue word is decoded from state so it stays stable while quo_rdy is low.
  always_comb begin
    quo_ctl = '0;
    quo_dat = '0;
    case (state)
      CMD: begin
        quo_ctl = CTL_OUT;
        case (mod)
          MOD_FAST: quo_dat[SDW-1:0] = 8'h0B;
          MOD_QUAD: quo_dat[SDW-1:0] = 8'h6B;
          default:  quo_dat[SDW-1:0] = 8'h03;
        endcase
      end
      AD2: begin
        quo_ctl          = CTL_OUT;
        quo_dat[SDW-1:0] = adr[23:16];
      end
      AD1: begin
        quo_ctl          = CTL_OUT;
        quo_dat[SDW-1:0] = adr[15:8];
      end
      AD0: begin
        quo_ctl          = CTL_OUT;
        quo_dat[SDW-1:0] = adr[7:0];
      end
      DUM: quo_ctl = CTL_DUM;
      DAT: begin
        if (mod == MOD_QUAD)      quo_ctl = CTL_QRDL;
        else if (dat_cnt == 2'd3) quo_ctl = CTL_RDL;
        else                      quo_ctl = CTL_RD;
      end
      HLD: quo_ctl = {cfg_hld, 7'h10};
      default: begin
        quo_ctl = '0;
        quo_dat = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Collector
  // ---------------------------------------------------------------------------
  // Quad capture interleaves nibbles over the four lanes: each received bit
  // pair (two clocks) across lanes 3..0 forms one byte, earliest byte first.
  for (genvar j = 0; j < 4; j++) begin : g_quad
    assign quad_word[j*8 +: 8] = {
      qui_dat[3*SDW + 7 - 2*j], qui_dat[2*SDW + 7 - 2*j],
      qui_dat[1*SDW + 7 - 2*j], qui_dat[0*SDW + 7 - 2*j],
      qui_dat[3*SDW + 6 - 2*j], qui_dat[2*SDW + 6 - 2*j],
      qui_dat[1*SDW + 6 - 2*j], qui_dat[0*SDW + 6 - 2*j]
    };
  end

  always_comb begin
    col_nxt = col_dat;
    if (qui_iom == IOM_QUAD) begin
      col_nxt = quad_word;
    end else if (qui_iom == IOM_SINGLE) begin
      case (col_cnt)
        2'd0:    col_nxt[7:0]   = qui_dat[2*SDW-1:SDW];
        2'd1:    col_nxt[15:8]  = qui_dat[2*SDW-1:SDW];
        2'd2:    col_nxt[23:16] = qui_dat[2*SDW-1:SDW];
        default: col_nxt[31:24] = qui_dat[2*SDW-1:SDW];
      endcase
    end
  end

  // Bytes are assembled in col_dat and copied to rsp_dat only on the last
  // word, so rsp_dat keeps the previous response during the next collection.
  always_ff @(posedge spi_sclk or posedge rst) begin
    if (rst) begin
      col_act <= 1'b0;
      col_cnt <= '0;
      col_dat <= '0;
      rsp_vld <= 1'b0;
      rsp_dat <= '0;
    end else begin
      if (req_fire) begin
        col_act <= 1'b1;
        col_cnt <= '0;
        col_dat <= '0;
      end
      if (rsp_vld && rsp_rdy) begin
        rsp_vld <= 1'b0;
      end
      if (qui_fire && col_act) begin
        col_dat <= col_nxt;
        if (qui_iom == IOM_SINGLE) begin
          col_cnt <= col_cnt + 2'd1;
        end
        if (qui_lst) begin
          rsp_vld <= 1'b1;
          rsp_dat <= col_nxt;
          col_act <= 1'b0;
          col_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sockit_spi_xip.sv
module tb_sockit_spi_xip;

  logic        spi_sclk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mod;
  logic [2:0]  cfg_hld;
  logic        req_vld;
  logic [23:0] req_adr;
  logic        req_rdy;
  logic        rsp_vld;
  logic [31:0] rsp_dat;
  logic        rsp_rdy;
  logic        quo_vld;
  logic [9:0]  quo_ctl;
  logic [31:0] quo_dat;
  logic        quo_rdy;
  logic        qui_vld;
  logic [3:0]  qui_ctl;
  logic [31:0] qui_dat;
  logic        qui_rdy;
  logic        bsy;

  int checks = 0;
  int errors = 0;

  sockit_spi_xip #(.SDW(8), .SDL(3)) dut (
    .spi_sclk (spi_sclk),
    .rst      (rst),
    .cfg_mod  (cfg_mod),
    .cfg_hld  (cfg_hld),
    .req_vld  (req_vld),
    .req_adr  (req_adr),
    .req_rdy  (req_rdy),
    .rsp_vld  (rsp_vld),
    .rsp_dat  (rsp_dat),
    .rsp_rdy  (rsp_rdy),
    .quo_vld  (quo_vld),
    .quo_ctl  (quo_ctl),
    .quo_dat  (quo_dat),
    .quo_rdy  (quo_rdy),
    .qui_vld  (qui_vld),
    .qui_ctl  (qui_ctl),
    .qui_dat  (qui_dat),
    .qui_rdy  (qui_rdy),
    .bsy      (bsy)
  );

  always #5 spi_sclk = ~spi_sclk;

  // One read transaction: request, bytes returned on the input queue (single
  // modes, in arrival order) or one quad word, expected command byte and
  // expected response.
  typedef struct {
    logic [1:0]  mod;
    logic [2:0]  hld;
    logic [23:0] adr;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] qd;
    logic [7:0]  cmd;
    logic [31:0] rsp;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [1:0] mod, input logic [2:0] hld,
                              input logic [23:0] adr,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [31:0] qd, input logic [7:0] cmd,
                              input logic [31:0] rsp);
    vec_t v;
    v.mod = mod; v.hld = hld; v.adr = adr;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.qd = qd; v.cmd = cmd; v.rsp = rsp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] eff_mod(input vec_t v);
    return (v.mod == 2'd3) ? 2'd0 : v.mod;
  endfunction

  function automatic int nwords(input vec_t v);
    int dum = (eff_mod(v) != 2'd0) ? 1 : 0;
    int nd  = (eff_mod(v) == 2'd2) ? 1 : 4;
    return 4 + dum + nd + 1;
  endfunction

  // Expected command-queue word number i of transaction v.
  task automatic exp_word(input vec_t v, input int i,
                          output logic [9:0] ctl, output logic [7:0] ln);
    int  k    = i;
    bit  quad = (eff_mod(v) == 2'd2);
    int  nd   = quad ? 1 : 4;
    ctl = 10'h000;
    ln  = 8'h00;
    if (k == 0) begin ctl = 10'h397; ln = v.cmd; end
    else if (k == 1) begin ctl = 10'h397; ln = v.adr[23:16]; end
    else if (k == 2) begin ctl = 10'h397; ln = v.adr[15:8]; end
    else if (k == 3) begin ctl = 10'h397; ln = v.adr[7:0]; end
    else begin
      k = k - 4;
      if (eff_mod(v) != 2'd0) begin
        if (k == 0) ctl = 10'h393;
        k = k - 1;
      end
      if (k >= 0) begin
        if (k < nd) ctl = quad ? 10'h3FB : ((k == nd - 1) ? 10'h3DB : 10'h39B);
        else        ctl = {v.hld, 7'h10};
      end
    end
  endtask

  task automatic check_word(input vec_t v, input int i);
    logic [9:0] ctl;
    logic [7:0] ln;
    exp_word(v, i, ctl, ln);
    chk($sformatf("quo_vld w%0d", i), 32'(quo_vld), 32'd1);
    chk($sformatf("quo_ctl w%0d", i), 32'(quo_ctl), 32'(ctl));
    chk($sformatf("quo_dat w%0d", i), quo_dat, {24'h0, ln});
  endtask

  // Returns at the negedge where the CMD word is presented.
  task automatic do_req(input vec_t v);
    int n = 0;
    cfg_mod = v.mod;
    cfg_hld = v.hld;
    req_adr = v.adr;
    req_vld = 1'b1;
    while (!req_rdy && n < 50) begin
      @(negedge spi_sclk);
      n++;
    end
    chk("req_rdy wait", 32'(req_rdy), 32'd1);
    @(negedge spi_sclk);
    req_vld = 1'b0;
    chk("bsy active", 32'(bsy), 32'd1);
  endtask

  task automatic do_words(input vec_t v, input int first);
    for (int i = first; i < nwords(v); i++) begin
      check_word(v, i);
      @(negedge spi_sclk);
    end
    chk("quo_vld idle", 32'(quo_vld), 32'd0);
  endtask

  task automatic do_rx(input vec_t v);
    logic [7:0] b;
    chk("qui_rdy", 32'(qui_rdy), 32'd1);
    if (eff_mod(v) == 2'd2) begin
      qui_vld = 1'b1;
      qui_ctl = 4'hF;
      qui_dat = v.qd;
      @(negedge spi_sclk);
    end else begin
      for (int i = 0; i < 4; i++) begin
        b = (i == 0) ? v.b0 : (i == 1) ? v.b1 : (i == 2) ? v.b2 : v.b3;
        qui_vld = 1'b1;
        qui_ctl = {(i == 0), (i == 3), 2'b01};
        qui_dat = {8'h5A, ~b, b, 8'hC3};
        @(negedge spi_sclk);
      end
    end
    qui_vld = 1'b0;
    qui_dat = '0;
    qui_ctl = '0;
  endtask

  task automatic check_rsp(input vec_t v, input bit take);
    chk("rsp_vld", 32'(rsp_vld), 32'd1);
    chk("rsp_dat", rsp_dat, v.rsp);
    chk("qui_rdy pend", 32'(qui_rdy), 32'd0);
    chk("req_rdy pend", 32'(req_rdy), 32'd0);
    chk("bsy pend", 32'(bsy), 32'd0);
    if (take) begin
      rsp_rdy = 1'b1;
      @(negedge spi_sclk);
      rsp_rdy = 1'b0;
      chk("rsp_vld taken", 32'(rsp_vld), 32'd0);
      chk("rsp_dat hold", rsp_dat, v.rsp);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit take);
    do_req(v);
    do_words(v, 0);
    do_rx(v);
    check_rsp(v, take);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(2'd0, 3'd0, 24'h123456, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 32'h0, 8'h03, 32'hD4C3B2A1);
    vecs[1] = mk(2'd1, 3'd3, 24'hABCDEF, 8'h11, 8'h22, 8'h33, 8'h44, 32'h0, 8'h0B, 32'h44332211);
    vecs[2] = mk(2'd2, 3'd1, 24'h000001, 8'h00, 8'h00, 8'h00, 8'h00, 32'h000000FF, 8'h6B, 32'h11111111);
    vecs[3] = mk(2'd2, 3'd7, 24'hFFFFFF, 8'h00, 8'h00, 8'h00, 8'h00, 32'hAA000000, 8'h6B, 32'h80808080);
    vecs[4] = mk(2'd3, 3'd2, 24'h800000, 8'h5A, 8'h00, 8'hFF, 8'hC3, 32'h0, 8'h03, 32'hC3FF005A);
    vecs[5] = mk(2'd1, 3'd0, 24'h000000, 8'h01, 8'h02, 8'h03, 8'h04, 32'h0, 8'h0B, 32'h04030201);

    rst = 1'b1;
    cfg_mod = 2'd0; cfg_hld = 3'd0;
    req_vld = 1'b0; req_adr = '0;
    rsp_rdy = 1'b0; quo_rdy = 1'b1;
    qui_vld = 1'b0; qui_ctl = '0; qui_dat = '0;

    #12;
    chk("rst quo_vld", 32'(quo_vld), 32'd0);
    chk("rst rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst rsp_dat", rsp_dat, 32'd0);
    chk("rst qui_rdy", 32'(qui_rdy), 32'd1);
    chk("rst req_rdy", 32'(req_rdy), 32'd1);
    chk("rst bsy", 32'(bsy), 32'd0);
    @(negedge spi_sclk);
    rst = 1'b0;
    @(negedge spi_sclk);

    // Input-queue word with no collection active is dropped.
    qui_vld = 1'b1; qui_ctl = 4'hF; qui_dat = 32'hFFFFFFFF;
    @(negedge spi_sclk);
    qui_vld = 1'b0; qui_ctl = '0; qui_dat = '0;
    @(negedge spi_sclk);
    chk("drop rsp_vld", 32'(rsp_vld), 32'd0);
    chk("drop bsy", 32'(bsy), 32'd0);
    chk("drop req_rdy", 32'(req_rdy), 32'd1);

    for (int t = 0; t < 6; t++) begin
      run_txn(vecs[t], 1'b1);
    end

    // Pending response blocks requests and input queue.
    run_txn(vecs[0], 1'b0);
    cfg_mod = vecs[1].mod; cfg_hld = vecs[1].hld; req_adr = vecs[1].adr;
    req_vld = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge spi_sclk);
      chk("stall req_rdy", 32'(req_rdy), 32'd0);
      chk("stall qui_rdy", 32'(qui_rdy), 32'd0);
      chk("stall quo_vld", 32'(quo_vld), 32'd0);
      chk("stall rsp_dat", rsp_dat, vecs[0].rsp);
    end
    rsp_rdy = 1'b1;
    @(negedge spi_sclk);
    rsp_rdy = 1'b0;
    chk("release rsp_vld", 32'(rsp_vld), 32'd0);
    chk("release req_rdy", 32'(req_rdy), 32'd1);
    do_req(vecs[1]);
    do_words(vecs[1], 0);
    do_rx(vecs[1]);
    check_rsp(vecs[1], 1'b1);

    // Command queue back-pressure while the AD1 word is presented.
    do_req(vecs[5]);
    check_word(vecs[5], 0);
    @(negedge spi_sclk);
    check_word(vecs[5], 1);
    @(negedge spi_sclk);
    quo_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_word(vecs[5], 2);
      @(negedge spi_sclk);
    end
    quo_rdy = 1'b1;
    check_word(vecs[5], 2);
    @(negedge spi_sclk);
    do_words(vecs[5], 3);
    do_rx(vecs[5]);
    check_rsp(vecs[5], 1'b1);

    // Reset in the middle of the data phase with a partial collection.
    do_req(vecs[0]);
    for (int i = 0; i < 4; i++) begin
      check_word(vecs[0], i);
      @(negedge spi_sclk);
    end
    check_word(vecs[0], 4);
    qui_vld = 1'b1; qui_ctl = 4'b1001; qui_dat = {8'h00, 8'h00, 8'hEE, 8'h00};
    @(negedge spi_sclk);
    qui_vld = 1'b0; qui_ctl = '0; qui_dat = '0;
    rst = 1'b1;
    #1;
    chk("mid rst quo_vld", 32'(quo_vld), 32'd0);
    chk("mid rst rsp_vld", 32'(rsp_vld), 32'd0);
    chk("mid rst rsp_dat", rsp_dat, 32'd0);
    chk("mid rst qui_rdy", 32'(qui_rdy), 32'd1);
    chk("mid rst req_rdy", 32'(req_rdy), 32'd1);
    chk("mid rst bsy", 32'(bsy), 32'd0);
    @(negedge spi_sclk);
    rst = 1'b0;
    @(negedge spi_sclk);
    run_txn(vecs[4], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
